// File: rtl/cell_pos_access_ctrl.sv
// Arbiter/sequencer for a single-port cell position RAM: addr 0 holds the particle count,
// addr 1..N hold positions. Serves a burst reader and a burst writer, one at a time.
module cell_pos_access_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_done,
    input  logic                  wr_req,
    output logic                  wr_gnt,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  wr_done,
    output logic                  err_overflow,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam int RD_LAT = 2;

    typedef enum logic [2:0] {
        IDLE, RD_CNT, RD_WAIT, RD_STREAM, RD_DRAIN, WR_STREAM, WR_CNT
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic                    rden_reg, rden_next;
    logic                    wren_reg, wren_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                    phase_reg, phase_next;
    logic                    zero_done_reg, zero_done_next;
    logic                    wr_done_reg, wr_done_next;
    logic                    err_reg, err_next;
    logic [RD_LAT-1:0]       rd_pipe_reg;
    logic [RD_LAT-1:0]       last_pipe_reg;
    logic                    issue, issue_last;
    logic [ADDR_WIDTH-1:0]   q_cnt, q_cnt_clamped;

    assign q_cnt         = ram_q[ADDR_WIDTH-1:0];
    assign q_cnt_clamped = (q_cnt > MAX_CNT) ? MAX_CNT : q_cnt;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        data_next      = data_reg;
        cnt_next       = cnt_reg;
        phase_next     = phase_reg;
        err_next       = err_reg;
        rden_next      = 1'b0;
        wren_next      = 1'b0;
        zero_done_next = 1'b0;
        wr_done_next   = 1'b0;
        rd_gnt         = 1'b0;
        wr_gnt         = 1'b0;
        issue          = 1'b0;
        issue_last     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Grants are combinational, so they are masked while reset is held
                if (!rst && rd_req) begin
                    rd_gnt     = 1'b1;
                    state_next = RD_CNT;
                    rden_next  = 1'b1;
                    addr_next  = '0;
                end else if (!rst && wr_req) begin
                    wr_gnt     = 1'b1;
                    state_next = WR_STREAM;
                    cnt_next   = '0;
                end
            end
            RD_CNT: begin
                state_next = RD_WAIT;
                phase_next = 1'b0;
            end
            RD_WAIT: begin
                if (!phase_reg) begin
                    phase_next = 1'b1;
                end else begin
                    cnt_next = q_cnt_clamped;
                    if (q_cnt_clamped == '0) begin
                        zero_done_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        state_next = RD_STREAM;
                        rden_next  = 1'b1;
                        addr_next  = ADDR_WIDTH'(1);
                    end
                end
            end
            RD_STREAM: begin
                issue      = 1'b1;
                issue_last = (addr_reg == cnt_reg);
                if (issue_last) begin
                    state_next = RD_DRAIN;
                    phase_next = 1'b0;
                end else begin
                    rden_next = 1'b1;
                    addr_next = addr_reg + ADDR_WIDTH'(1);
                end
            end
            RD_DRAIN: begin
                if (phase_reg) state_next = IDLE;
                else           phase_next = 1'b1;
            end
            WR_STREAM: begin
                if (wr_valid) begin
                    // Beats beyond capacity are still consumed so the writer never stalls
                    if (cnt_reg < MAX_CNT) begin
                        cnt_next  = cnt_reg + ADDR_WIDTH'(1);
                        wren_next = 1'b1;
                        addr_next = cnt_reg + ADDR_WIDTH'(1);
                        data_next = wr_data;
                    end else begin
                        err_next = 1'b1;
                    end
                    if (wr_last) begin
                        state_next = WR_CNT;
                        phase_next = 1'b0;
                    end
                end
            end
            WR_CNT: begin
                if (!phase_reg) begin
                    phase_next   = 1'b1;
                    wren_next    = 1'b1;
                    addr_next    = '0;
                    data_next    = DATA_WIDTH'(cnt_reg);
                    wr_done_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            data_reg      <= '0;
            rden_reg      <= 1'b0;
            wren_reg      <= 1'b0;
            cnt_reg       <= '0;
            phase_reg     <= 1'b0;
            zero_done_reg <= 1'b0;
            wr_done_reg   <= 1'b0;
            err_reg       <= 1'b0;
            rd_pipe_reg   <= '0;
            last_pipe_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            rden_reg      <= rden_next;
            wren_reg      <= wren_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            zero_done_reg <= zero_done_next;
            wr_done_reg   <= wr_done_next;
            err_reg       <= err_next;
            // Tracks each stream read through the RAM's read latency
            rd_pipe_reg   <= {rd_pipe_reg[RD_LAT-2:0], issue};
            last_pipe_reg <= {last_pipe_reg[RD_LAT-2:0], issue_last};
        end
    end

    assign rd_valid     = rd_pipe_reg[RD_LAT-1];
    assign rd_last      = last_pipe_reg[RD_LAT-1];
    assign rd_done      = last_pipe_reg[RD_LAT-1] | zero_done_reg;
    assign rd_data      = rd_pipe_reg[RD_LAT-1] ? ram_q : '0;
    assign wr_ready     = (state_reg == WR_STREAM);
    assign wr_done      = wr_done_reg;
    assign err_overflow = err_reg;
    assign busy         = (state_reg != IDLE);
    assign ram_address  = addr_reg;
    assign ram_data     = data_reg;
    assign ram_rden     = rden_reg;
    assign ram_wren     = wren_reg;

endmodule
